// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared widths and the converter result record for the
// fpcvt_arbiter slice.
package fpcvt_pkg;

  localparam int D_W = 12;  // two's-complement sample width
  localparam int E_W = 3;   // exponent width
  localparam int F_W = 4;   // significand width

  // Converter result: value = f * 2^e, sign carried separately.
  typedef struct packed {
    logic           s;
    logic [E_W-1:0] e;
    logic [F_W-1:0] f;
  } fp_t;

endpackage

// File: rtl/FPCVT.sv
// FPCVT: combinational 12-bit two's-complement to sign/exponent/significand
// converter.
//   D  in  12  sample
//   S  out 1   sign (D[11])
//   E  out 3   exponent
//   F  out 4   significand, value = F * 2^E
module FPCVT (
  input  logic [11:0] D,
  output logic        S,
  output logic [2:0]  E,
  output logic [3:0]  F
);

  logic [11:0] neg;
  logic [10:0] mag;
  logic [3:0]  lead;
  logic [2:0]  sh;
  logic [3:0]  shm1;
  logic [3:0]  f_t;
  logic        rnd;

  assign neg = 12'(-D);

  always_comb begin
    // -2048 has no positive 11-bit counterpart; clamp to 2047.
    if (D[11]) mag = (D == 12'h800) ? 11'h7FF : neg[10:0];
    else       mag = D[10:0];

    lead = 4'd0;
    for (int i = 0; i < 11; i++)
      if (mag[i]) lead = 4'(i);

    // Shift so the leading one lands in F[3]; small values stay exact.
    sh   = (lead > 4'd3) ? 3'(lead - 4'd3) : 3'd0;
    shm1 = {1'b0, sh} - 4'd1;
    f_t  = 4'(mag >> sh);
    rnd  = (sh != 3'd0) ? 1'(mag >> shm1) : 1'b0;

    S = D[11];
    E = sh;
    F = f_t;
    if (rnd) begin
      if (f_t == 4'hF) begin
        // Carry out of the significand renormalises, unless E is already max.
        if (sh != 3'd7) begin
          F = 4'h8;
          E = sh + 3'd1;
        end
      end else begin
        F = f_t + 4'd1;
      end
    end
  end

endmodule

// File: rtl/fpcvt_rr_arb.sv
// fpcvt_rr_arb: round-robin grant logic.
//   req        in  NREQ  request vector
//   ptr        in  IDW   highest-priority index
//   grant      out NREQ  one-hot grant (zero when no request)
//   grant_idx  out IDW   index of the granted request
module fpcvt_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // Search ptr, ptr+1, ... wrapping at NREQ; first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpcvt_arbiter.sv
// fpcvt_arbiter: shares one FPCVT converter among NREQ requesters through a
// round-robin arbiter and a two-stage valid/ready pipeline.
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid/data  per-requester samples (12 bits each, packed)
//   req_ready       per-requester accept (one-hot or zero)
//   out_valid/ready result handshake; out_s/e/f result, out_id origin
//   done_cnt        completed output handshakes (wraps)
//   busy            either pipeline stage occupied
module fpcvt_arbiter
  import fpcvt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [D_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_s,
  output logic [E_W-1:0]      out_e,
  output logic [F_W-1:0]      out_f,
  output logic [IDW-1:0]      out_id,
  output logic [15:0]         done_cnt,
  output logic                busy
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any_grant, ld0, ld1, hs;
  logic [D_W-1:0]  d_sel;
  fp_t             cvt;

  logic            v0_q, v0_d;
  logic [D_W-1:0]  d0_q, d0_d;
  logic [IDW-1:0]  id0_q, id0_d;
  logic            out_valid_q, out_valid_d;
  fp_t             out_q, out_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [15:0]     done_cnt_q, done_cnt_d;

  fpcvt_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  FPCVT u_cvt (
    .D (d0_q),
    .S (cvt.s),
    .E (cvt.e),
    .F (cvt.f)
  );

  assign any_grant = |grant;
  assign ld1       = !out_valid_q | out_ready;
  assign ld0       = !v0_q | ld1;
  assign hs        = ld0 & any_grant & rst_n;
  assign d_sel     = req_data[grant_idx*D_W +: D_W];
  assign req_ready = rst_n ? (grant & {NREQ{ld0}}) : '0;

  always_comb begin
    v0_d        = v0_q;
    d0_d        = d0_q;
    id0_d       = id0_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    done_cnt_d  = done_cnt_q + 16'(out_valid_q & out_ready);

    if (ld1) begin
      out_valid_d = v0_q;
      out_d       = cvt;
      out_id_d    = id0_q;
    end
    if (ld0) begin
      v0_d = any_grant;
      if (any_grant) begin
        d0_d  = d_sel;
        id0_d = grant_idx;
      end
    end
    if (hs)
      ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      d0_q        <= '0;
      id0_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
      done_cnt_q  <= '0;
    end else begin
      v0_q        <= v0_d;
      d0_q        <= d0_d;
      id0_q       <= id0_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_q.s;
  assign out_e     = out_q.e;
  assign out_f     = out_q.f;
  assign out_id    = out_id_q;
  assign done_cnt  = done_cnt_q;
  assign busy      = v0_q | out_valid_q;

endmodule

// File: tb/tb_fpcvt_arbiter.sv
module tb_fpcvt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [47:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic [1:0]  out_id;
  logic [15:0] done_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpcvt_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_id    (out_id),
    .done_cnt  (done_cnt),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int i, input logic [11:0] v);
    req_data[i*12 +: 12] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkout(input string tag, input logic s, input logic [2:0] e,
                        input logic [3:0] f, input logic [1:0] id);
    chk({tag, "_v"},  32'(out_valid), 32'd1);
    chk({tag, "_s"},  32'(out_s),     32'(s));
    chk({tag, "_e"},  32'(out_e),     32'(e));
    chk({tag, "_f"},  32'(out_f),     32'(f));
    chk({tag, "_id"}, 32'(out_id),    32'(id));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0001;
    req_data  = '0;
    out_ready = 1'b1;

    // Reset state; req_ready forced low even with a request pending.
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_oval",  32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_cnt",   32'(done_cnt),  32'd0);
    chk("rst_ptr",   32'(dut.ptr_q), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single request: 422 -> E=5 F=13.
    setd(0, 12'd422); req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    tick(); req_valid = '0;
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chkout("t1", 1'b0, 3'd5, 4'd13, 2'd0);
    tick();
    chk("t1_cnt",  32'(done_cnt),  32'd1);
    chk("t1_oval", 32'(out_valid), 32'd0);

    // Round-up overflow then -2048 saturation, back to back from requester 2.
    setd(2, 12'd125); req_valid = 4'b0100;
    tick();
    setd(2, 12'h800);
    tick(); req_valid = '0;
    chkout("t2a", 1'b0, 3'd4, 4'd8, 2'd2);
    tick();
    chkout("t2b", 1'b1, 3'd7, 4'd15, 2'd2);
    tick();
    chk("t2_cnt", 32'(done_cnt), 32'd3);

    // Fairness: fresh reset so the pointer starts at 0.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) setd(i, 12'(i + 1));
    req_valid = 4'hF;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k >= 2 && k <= 13) begin
        chk("rr_v",  32'(out_valid), 32'd1);
        chk("rr_id", 32'(out_id),    32'((k - 2) % 4));
        chk("rr_f",  32'(out_f),     32'(((k - 2) % 4) + 1));
      end
      if (k == 12) req_valid = '0;
    end
    chk("rr_cnt",  32'(done_cnt), 32'd12);
    chk("rr_busy", 32'(busy),     32'd0);

    // Backpressure: ptr is 0, requesters 1 and 3 valid, consumer stalled.
    out_ready = 1'b0;
    setd(1, 12'h010);   // 16 -> E=1 F=8
    setd(3, 12'hFF9);   // -7 -> S=1 E=0 F=7
    req_valid = 4'b1010;
    #1 chk("bp_rdy0", 32'(req_ready), 32'b0010);
    tick();
    chk("bp_rdy1", 32'(req_ready), 32'b1000);
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk("bp_rdy",  32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy),      32'd1);
      chkout("bp_hold", 1'b0, 3'd1, 4'd8, 2'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 32'(req_ready), 32'b0010);
    tick(); req_valid = '0;
    chkout("bp_o2", 1'b1, 3'd0, 4'd7, 2'd3);
    tick();
    chkout("bp_o3", 1'b0, 3'd1, 4'd8, 2'd1);
    tick();
    chk("bp_cnt",  32'(done_cnt),  32'd15);
    chk("bp_oval", 32'(out_valid), 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    setd(0, 12'd5); req_valid = 4'b0001;
    tick(); tick();
    chk("mr_full_v", 32'(out_valid), 32'd1);
    chk("mr_full_0", 32'(dut.v0_q),  32'd1);
    rst_n = 1'b0;
    #1 chk("mr_rdy", 32'(req_ready), 32'd0);
    tick();
    chk("mr_oval", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy),      32'd0);
    chk("mr_ptr",  32'(dut.ptr_q), 32'd0);
    chk("mr_cnt",  32'(done_cnt),  32'd0);
    rst_n = 1'b1; req_valid = '0; out_ready = 1'b1;
    tick(); tick();
    chk("mr_stale", 32'(out_valid), 32'd0);

    // Zero input.
    setd(0, 12'd0); req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick();
    chkout("zero", 1'b0, 3'd0, 4'd0, 2'd0);
    tick();
    chk("zero_cnt", 32'(done_cnt), 32'd1);

    // Counter wrap: stream 65534 more to reach 0xFFFF, then one more.
    setd(0, 12'd9); req_valid = 4'b0001;
    for (int k = 0; k < 65534; k++) tick();
    req_valid = '0;
    tick(); tick();
    chk("wrap_max", 32'(done_cnt), 32'hFFFF);
    req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick(); tick();
    chk("wrap_zero", 32'(done_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
